// File: rtl/pad_event_pkg.sv
// Shared sizing defaults and the pad index type for the launchpad pad front end.
package pad_event_pkg;
  localparam int NUM_PADS_DEF        = 8;
  localparam int PAD_ID_W            = $clog2(NUM_PADS_DEF);
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF      = 4;

  typedef logic [PAD_ID_W-1:0] pad_id_t;
endpackage

// File: rtl/pad_debouncer.sv
// One pad: 2-flop synchronizer plus debouncer. The level flips DEBOUNCE_CYCLES+2 edges after the raw change.
// rise pulses combinationally in the cycle whose edge flips the level 0->1. There is no backpressure.
module pad_debouncer import pad_event_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // The level is allowed to flip only once the counter has seen DEBOUNCE_CYCLES-1 prior differing samples.
  assign settle = (sync1 != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle && sync1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= pad_raw;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_event_encoder.sv
// Debounces the pads, latches presses as pending bits, and queues them lowest index first into a FIFO with no fall-through.
// A press shows on evt_valid DEBOUNCE_CYCLES+3 edges after the pin goes high. A full FIFO holds presses in pending; a repeat press on a still-pending pad sets ovf.
module pad_event_encoder import pad_event_pkg::*; #(
  parameter int NUM_PADS        = NUM_PADS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PADS-1:0]         pad_in,
  input  logic                        evt_ready,
  input  logic                        ovf_clr,
  output logic                        evt_valid,
  output logic [$clog2(NUM_PADS)-1:0] evt_id,
  output logic [NUM_PADS-1:0]         pressed,
  output logic                        ovf
);

  localparam int ID_W  = $clog2(NUM_PADS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_PADS-1:0] rise;
  logic [NUM_PADS-1:0] pending;
  logic [NUM_PADS-1:0] sel_mask;
  logic [NUM_PADS-1:0] grant_mask;
  logic [ID_W-1:0]     grant_id;
  logic                push;
  logic                pop;
  logic                full;
  logic                ovf_set;

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .pad_raw (pad_in[g]),
      .level   (pressed[g]),
      .rise    (rise[g])
    );
  end

  // Scanning from the top down leaves the lowest set index selected.
  always_comb begin
    grant_id = '0;
    sel_mask = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_id    = ID_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid  = (count != '0);
  assign evt_id     = mem[rd_ptr];
  assign pop        = evt_valid && evt_ready;
  assign push       = (|pending) && (!full || pop);
  assign grant_mask = push ? sel_mask : '0;
  // A press on a pad whose previous press is leaving this cycle is a fresh event, not an overflow.
  assign ovf_set    = |(rise & pending & ~grant_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~grant_mask) | rise;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= grant_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pad_event_encoder.sv
// Directed scoreboard bench: stimulus queues the expected pad ids, and a negedge monitor checks each handshake against them.
module tb_pad_event_encoder;
  import pad_event_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    pad_in = '0;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          evt_valid;
  logic [2:0]    evt_id;
  logic [7:0]    pressed;
  logic          ovf;

  int            n_checks = 0;
  int            n_fail   = 0;
  pad_id_t       sb_q[$];

  pad_event_encoder #(.NUM_PADS(8), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pad_in    (pad_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pressed   (pressed),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns 1 ns after the n-th rising edge, where inputs are driven and outputs sampled.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input pad_id_t id);
    sb_q.push_back(id);
  endtask

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got id %0d expected no event", evt_id);
      end else begin
        pad_id_t exp_id;
        exp_id = sb_q.pop_front();
        if (evt_id !== exp_id) begin
          n_fail++;
          $display("FAIL event_order: got id %0d expected %0d", evt_id, exp_id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    wait_edges(2);
    check("reset_evt_valid", 32'(evt_valid), 0);
    check("reset_evt_id", 32'(evt_id), 0);
    check("reset_pressed", 32'(pressed), 0);
    check("reset_ovf", 32'(ovf), 0);
    rst = 1'b1;
    wait_edges(2);

    // Single press on pad 3 with the consumer ready.
    evt_ready = 1'b1;
    pad_in[3] = 1'b1;
    expect_evt(3'd3);
    wait_edges(5);
    check("single_pressed_e5", 32'(pressed[3]), 0);
    wait_edges(1);
    check("single_pressed_e6", 32'(pressed[3]), 1);
    check("single_valid_e6", 32'(evt_valid), 0);
    wait_edges(1);
    check("single_valid_e7", 32'(evt_valid), 1);
    check("single_id_e7", 32'(evt_id), 3);
    wait_edges(1);
    check("single_valid_e8", 32'(evt_valid), 0);
    wait_edges(12);
    pad_in[3] = 1'b0;
    wait_edges(10);
    check("single_release", 32'(pressed), 0);
    check("single_ovf", 32'(ovf), 0);

    // A three-cycle glitch on pad 5 must be rejected.
    pad_in[5] = 1'b1;
    seen = 1'b0;
    wait_edges(3);
    pad_in[5] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_edges(1);
      if (pressed[5] || evt_valid) seen = 1'b1;
    end
    check("glitch_rejected", 32'(seen), 0);

    // Pads 6, 1, 4 together come out lowest index first.
    pad_in = 8'h52;
    expect_evt(3'd1);
    expect_evt(3'd4);
    expect_evt(3'd6);
    wait_edges(7);
    check("simul_valid_e7", 32'(evt_valid), 1);
    wait_edges(2);
    check("simul_valid_e9", 32'(evt_valid), 1);
    check("simul_id_e9", 32'(evt_id), 6);
    wait_edges(1);
    check("simul_valid_e10", 32'(evt_valid), 0);
    pad_in = '0;
    wait_edges(10);

    // Backpressure: FIFO fills with 0..3, pads 4 and 5 wait in pending.
    evt_ready = 1'b0;
    pad_in = 8'h3F;
    for (int i = 0; i < 6; i++) expect_evt(pad_id_t'(i));
    wait_edges(12);
    check("bp_valid_full", 32'(evt_valid), 1);
    check("bp_head_held", 32'(evt_id), 0);
    pad_in[5] = 1'b0;
    wait_edges(10);
    check("bp_pad5_released", 32'(pressed[5]), 0);
    pad_in[5] = 1'b1;
    wait_edges(5);
    check("bp_ovf_before", 32'(ovf), 0);
    wait_edges(1);
    check("bp_ovf_set", 32'(ovf), 1);
    evt_ready = 1'b1;
    wait_edges(1);
    check("bp_push_pop_valid", 32'(evt_valid), 1);
    check("bp_push_pop_head", 32'(evt_id), 1);
    wait_edges(5);
    check("bp_drained", 32'(evt_valid), 0);
    check("bp_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    wait_edges(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 0);
    pad_in = '0;
    wait_edges(10);

    // Full FIFO with pad 7 pending: push and pop share an edge, 7 comes out last.
    evt_ready = 1'b0;
    pad_in = 8'h8F;
    expect_evt(3'd0);
    expect_evt(3'd1);
    expect_evt(3'd2);
    expect_evt(3'd3);
    expect_evt(3'd7);
    wait_edges(12);
    check("full_head", 32'(evt_id), 0);
    evt_ready = 1'b1;
    wait_edges(1);
    check("full_pp_valid", 32'(evt_valid), 1);
    check("full_pp_head", 32'(evt_id), 1);
    wait_edges(3);
    check("full_last_valid", 32'(evt_valid), 1);
    check("full_last_id", 32'(evt_id), 7);
    wait_edges(1);
    check("full_empty", 32'(evt_valid), 0);
    pad_in = '0;
    wait_edges(10);

    // Reset with two events queued while pad 2 stays held.
    evt_ready = 1'b0;
    pad_in = 8'h05;
    expect_evt(3'd0);
    expect_evt(3'd2);
    wait_edges(9);
    check("rst_pre_head", 32'(evt_id), 0);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("rst_async_valid", 32'(evt_valid), 0);
    check("rst_async_pressed", 32'(pressed), 0);
    check("rst_async_ovf", 32'(ovf), 0);
    pad_in = 8'h04;
    wait_edges(2);
    check("rst_hold_valid", 32'(evt_valid), 0);
    rst = 1'b1;
    evt_ready = 1'b1;
    expect_evt(3'd2);
    wait_edges(6);
    check("rst_evt_e6", 32'(evt_valid), 0);
    wait_edges(1);
    check("rst_evt_e7_valid", 32'(evt_valid), 1);
    check("rst_evt_e7_id", 32'(evt_id), 2);
    wait_edges(1);
    check("rst_evt_e8", 32'(evt_valid), 0);
    pad_in = '0;
    wait_edges(10);

    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_event_encoder.md
# pad_event_encoder

Input-side front end for the launchpad: debounces the raw pad buttons and turns each press into a queued event record. The event display blocks and the sound sequencer consume these records through a valid/ready handshake. The block runs on the single system clock and never drives the seven-segment outputs itself.

## Interface
- NUM_PADS, 8, number of pad buttons; must be a power of two, at most 16
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before the debounced level changes; minimum 2
- FIFO_DEPTH, 4, event queue depth; must be a power of two
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pad_in  in  NUM_PADS  raw, asynchronous button levels (1 = pressed)
- evt_ready  in  1  consumer accepts the head event
- ovf_clr  in  1  one-cycle pulse that clears ovf
- evt_valid  out  1  head event present
- evt_id  out  log2(NUM_PADS)  index of the pressed pad
- pressed  out  NUM_PADS  debounced pad levels
- ovf  out  1  sticky flag: a press was lost

## Operation
- Per-pad pipeline:
  - Two-flop synchronizer, then a debouncer.
  - The debounce counter increments each cycle the synchronized level differs from the debounced level.
  - The counter clears to 0 when the two levels are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips at that edge and the counter clears.
- Press detect: a 0->1 flip of the debounced level sets pending[i] at the same edge. A 1->0 flip (release) produces no event.
- Arbiter: each cycle, the lowest-index set pending bit is pushed into the FIFO and cleared, provided the FIFO is not full or is popped in that cycle. At most one push per cycle.
- Pending bits persist while the FIFO is full. No press is dropped unless the rule below applies.
- Overflow:
  - Trigger: a new debounced press on pad i while pending[i] is still set.
  - Effect: ovf is set and pending[i] stays set, so only one event is recorded.
  - Clearing: ovf clears only on ovf_clr or reset. If ovf_clr and a new overflow occur in the same cycle, ovf ends up set.
- FIFO and handshake:
  - evt_valid = FIFO not empty; evt_id = head entry.
  - A pop occurs when evt_valid && evt_ready.
  - Once evt_valid is asserted, evt_id is held stable until the pop.
- Reset values: evt_valid 0, evt_id 0, pressed all 0, ovf 0. Synchronizers, counters, pending bits and FIFO pointers are all cleared.
- Reset mid-operation: queued and pending events are discarded. A pad held through reset release is reported as a new press once debounced.

## Timing
- Press latency, measured from the first edge that samples pad_in[i] high (idle pad, empty FIFO, no other pending):
  - debounced high and pending set at edge 2+DEBOUNCE_CYCLES;
  - FIFO push at edge 3+DEBOUNCE_CYCLES;
  - evt_valid high after edge 3+DEBOUNCE_CYCLES, i.e. edge 7 at defaults.
- Glitch rejection: pulses shorter than DEBOUNCE_CYCLES synchronized cycles never change pressed.
- Full FIFO: a push and a pop in the same cycle are both legal. Occupancy is unchanged and ordering is preserved.
- Empty FIFO: there is no fall-through. A pushed entry becomes visible on the next cycle.
- Throughput: one event per cycle when evt_ready is held high.

## Structure
- Shared package pad_event_pkg holds:
  - NUM_PADS_DEF, PAD_ID_W = $clog2(NUM_PADS_DEF);
  - typedef pad_id_t;
  - DEBOUNCE_CYCLES_DEF.
- One sub-module, pad_debouncer: synchronizer, counter and debounced level for one pad, plus a rise pulse output. It is instantiated NUM_PADS times in a generate loop.
- The arbiter (priority encoder) and the circular FIFO (read/write pointers plus a count) are implemented inline in pad_event_encoder.

## Test plan
- Single press: hold pad_in[3] high for 20 cycles with evt_ready=1 -> evt_valid is high for exactly one cycle after edge 7 with evt_id=3; pressed[3]=1 from edge 6; ovf stays 0.
- Glitch: pad_in[5] high for 3 cycles, then low -> pressed stays 0, no event.
- Simultaneous press: pads 6, 1 and 4 rise in the same cycle with evt_ready=1 -> events 1, 4, 6 on consecutive cycles.
- Backpressure and overflow:
  - Hold evt_ready=0 and press pads 0..5 -> FIFO holds 0,1,2,3 and pending holds 4,5.
  - Release pad 5, then press it again while pending -> ovf=1.
  - Then raise evt_ready -> events 0,1,2,3,4,5 each exactly once; ovf_clr -> ovf=0.
- Full plus simultaneous pop: with the FIFO full, pending[7] set and evt_ready=1 -> push and pop happen in the same cycle, occupancy stays 4, and 7 emerges last.
- Reset mid-operation: with 2 events queued, pulse rst low while pad 2 stays held -> evt_valid=0, pressed=0, ovf=0 during reset; after release, a single event with evt_id=2 after DEBOUNCE_CYCLES+3 edges.
